// File: rtl/soc_system_pio_status_edge.sv
// Avalon-MM input PIO: synchronised status lines, per-bit edge capture with
// write-1-to-clear, maskable level interrupt and registered read data.
module soc_system_pio_status_edge #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] PRIME_MAX = CW'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic [CW-1:0]    prime_q, prime_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;
  logic             primed;

  if (WIDTH < 32) begin : g_pad
    logic unused_wd;
    assign unused_wd = ^writedata[31:WIDTH];
  end

  always_comb begin
    s      = sync_q[SYNC_STAGES-1];
    wr_en  = chipselect & ~write_n;
    primed = (prime_q == PRIME_MAX);
    prime_d = primed ? prime_q : prime_q + CW'(1);

    // Held off until the sync chain and prev hold post-reset samples only.
    det = '0;
    if (primed) begin
      if (EDGE_TYPE == 0)      det = s & ~prev_q;
      else if (EDGE_TYPE == 1) det = ~s & prev_q;
      else                     det = s ^ prev_q;
    end

    clr = '0;
    if (wr_en && address == 2'd3) clr = writedata[WIDTH-1:0];
    // Set wins over a simultaneous clear of the same bit.
    edge_capture_d = (edge_capture_q & ~clr) | det;

    irqmask_d = irqmask_q;
    if (wr_en && address == 2'd1) irqmask_d = writedata[WIDTH-1:0];

    case (address)
      2'd0:    readdata_d = 32'(s);
      2'd1:    readdata_d = 32'(irqmask_q);
      2'd3:    readdata_d = 32'(edge_capture_q);
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q         <= '0;
      irqmask_q      <= '0;
      edge_capture_q <= '0;
      readdata_q     <= '0;
      prime_q        <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q         <= s;
      irqmask_q      <= irqmask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
      prime_q        <= prime_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irqmask_q);

endmodule

// File: tb/tb_soc_system_pio_status_edge.sv
// Scoreboard bench for soc_system_pio_status_edge: three configurations share one
// bus; a sample-history reference model predicts readdata/irq for every clock.
module tb_soc_system_pio_status_edge;

  localparam int NI = 3;
  localparam int WC [NI] = '{8, 4, 32};
  localparam int SC [NI] = '{2, 3, 4};
  localparam int EC [NI] = '{0, 1, 2};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] in_v [NI];
  logic [31:0] rd   [NI];
  logic [NI-1:0] irq_w;

  always #5 clk = ~clk;

  soc_system_pio_status_edge #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[0]),
    .in_port(in_v[0][7:0]), .irq(irq_w[0]));

  soc_system_pio_status_edge #(.WIDTH(4), .SYNC_STAGES(3), .EDGE_TYPE(1)) u1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[1]),
    .in_port(in_v[1][3:0]), .irq(irq_w[1]));

  soc_system_pio_status_edge #(.WIDTH(32), .SYNC_STAGES(4), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[2]),
    .in_port(in_v[2]), .irq(irq_w[2]));

  typedef struct packed {
    logic [NI-1:0][31:0] rd;
    logic [NI-1:0]       irq;
  } exp_t;

  exp_t sb_q [$];
  int   total = 0;
  int   bad   = 0;
  int   cycno = 0;

  // Reference model: samp[k][n] is the in_port value taken at the n-th edge
  // after reset; the synchronised view lags it by SYNC_STAGES-1 samples.
  int          ecnt = 0;
  logic [31:0] samp   [NI][0:4095];
  logic [31:0] m_cap  [NI];
  logic [31:0] m_mask [NI];
  logic [31:0] cur    [NI];

  function automatic logic [31:0] wmask(input int k);
    return 32'hFFFF_FFFF >> (32 - WC[k]);
  endfunction

  function automatic logic [31:0] s_after(input int k, input int n);
    if (n >= SC[k]) return samp[k][n - SC[k] + 1];
    return 32'h0;
  endfunction

  task automatic cyc(input logic r, input logic [1:0] a, input logic cs, input logic wn,
                     input logic [31:0] wd);
    exp_t ex;
    logic [31:0] d, x, y, clr;
    @(negedge clk);
    reset = r; address = a; chipselect = cs; write_n = wn; writedata = wd;
    for (int k = 0; k < NI; k++) in_v[k] = cur[k];
    ex = '0;
    if (r) begin
      ecnt = 0;
      for (int k = 0; k < NI; k++) begin
        m_cap[k]  = 32'h0;
        m_mask[k] = 32'h0;
      end
    end else begin
      ecnt++;
      for (int k = 0; k < NI; k++) begin
        samp[k][ecnt] = cur[k] & wmask(k);
        case (a)
          2'd0:    ex.rd[k] = s_after(k, ecnt - 1);
          2'd1:    ex.rd[k] = m_mask[k];
          2'd3:    ex.rd[k] = m_cap[k];
          default: ex.rd[k] = 32'h0;
        endcase
        d = 32'h0;
        // Only transitions between two post-reset samples count as edges.
        if (ecnt >= SC[k] + 2) begin
          x = s_after(k, ecnt - 1);
          y = s_after(k, ecnt - 2);
          if (EC[k] == 0)      d = x & ~y;
          else if (EC[k] == 1) d = ~x & y;
          else                 d = x ^ y;
        end
        clr = (cs && !wn && a == 2'd3) ? wd : 32'h0;
        m_cap[k] = ((m_cap[k] & ~clr) | d) & wmask(k);
        if (cs && !wn && a == 2'd1) m_mask[k] = wd & wmask(k);
        ex.irq[k] = |(m_cap[k] & m_mask[k]);
      end
    end
    sb_q.push_back(ex);
  endtask

  task automatic tick(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, a, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    cyc(1'b0, a, 1'b1, 1'b0, wd);
  endtask

  // Monitor: one expectation per clock edge, checked just after the edge.
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      cycno++;
      if (sb_q.size() > 0) begin
        ex = sb_q.pop_front();
        for (int k = 0; k < NI; k++) begin
          total++;
          if (rd[k] !== ex.rd[k]) begin
            bad++;
            $display("FAIL readdata u%0d cycle %0d addr %0d: got %h want %h",
                     k, cycno, address, rd[k], ex.rd[k]);
          end
          total++;
          if (irq_w[k] !== ex.irq[k]) begin
            bad++;
            $display("FAIL irq u%0d cycle %0d: got %b want %b", k, cycno, irq_w[k], ex.irq[k]);
          end
        end
      end
    end
  end

  initial begin
    cur[0] = 32'hFF; cur[1] = 32'hF; cur[2] = 32'hFFFF_FFFF;
    for (int k = 0; k < NI; k++) in_v[k] = cur[k];

    // Lines high through reset must not produce edges.
    for (int i = 0; i < 3; i++) cyc(1'b1, 2'd3, 1'b0, 1'b1, 32'h0);
    tick(2'd3, 8);
    tick(2'd0, 5);

    wr(2'd1, 32'h1);
    cur[0] = 32'h0; cur[2] = 32'h0;
    tick(2'd3, 7);
    wr(2'd3, 32'hFFFF_FFFF);
    tick(2'd3, 2);

    // Rising capture on u0, then w1c of bit 0.
    cur[0] = 32'h05;
    tick(2'd3, 4);
    wr(2'd3, 32'h1);
    tick(2'd3, 2);

    // New rising edge on bit 2 coincides with a clear of bit 2 (u0, S=2).
    cur[0] = 32'h01;
    tick(2'd3, 4);
    cur[0] = 32'h05;
    tick(2'd3, 2);
    wr(2'd3, 32'h4);
    tick(2'd3, 3);

    // Falling edges on u1.
    wr(2'd3, 32'hFFFF_FFFF);
    cur[1] = 32'h3;
    tick(2'd3, 6);
    cur[1] = 32'hF;
    tick(2'd3, 6);

    // Any-edge on u2 bit 31 with a clear between the two edges.
    wr(2'd3, 32'hFFFF_FFFF);
    tick(2'd3, 3);
    cur[2] = 32'h8000_0000;
    tick(2'd3, 7);
    wr(2'd3, 32'h8000_0000);
    tick(2'd3, 2);
    cur[2] = 32'h0;
    tick(2'd3, 7);
    wr(2'd1, 32'hFFFF_FFFF);
    tick(2'd1, 2);

    // Reserved address, writes to DATA and reserved ignored.
    tick(2'd2, 2);
    wr(2'd2, 32'hFFFF_FFFF);
    wr(2'd0, 32'hFFFF_FFFF);
    tick(2'd0, 3);
    tick(2'd3, 2);

    // Mid-operation reset with captures pending, lines left high.
    cur[0] = 32'hFF; cur[1] = 32'h0; cur[2] = 32'h1234_5678;
    tick(2'd3, 7);
    cyc(1'b1, 2'd3, 1'b0, 1'b1, 32'h0);
    tick(2'd3, 8);
    tick(2'd0, 2);
    wr(2'd1, 32'hFFFF_FFFF);
    tick(2'd1, 2);

    for (int i = 0; i < 2000; i++) begin
      logic        r;
      logic [31:0] wd;
      for (int k = 0; k < NI; k++)
        if ($urandom_range(3) == 0) cur[k] = $urandom;
      r  = ($urandom_range(299) == 0) || (ecnt > 4000);
      wd = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
      cyc(r, 2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)), wd);
    end

    @(posedge clk);
    #2;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
